ls_unit: RTL and testbench
==========================

LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port m_valid_i  in  1  upstream entry valid.
REQ-005 SHALL have port m_ready_o  out  1  unit accepts entry this cycle.
REQ-006 SHALL have port m_pc_i  in  XLEN  entry PC.
REQ-007 SHALL have port m_rd_i  in  5  destination register.
REQ-008 SHALL have port m_wenReg_i  in  1  register write enable.
REQ-009 SHALL have port m_wenMem_i  in  1  store.
REQ-010 SHALL have port m_renMem_i  in  1  load.
REQ-011 SHALL have port m_is_load_signed_i  in  1  sign-extend load data.
REQ-012 SHALL have port m_mask_i  in  4  size: 0001 byte, 0011 half, 1111 word.
REQ-013 SHALL have port m_res_i  in  XLEN  ALU result; memory address for loads/stores.
REQ-014 SHALL have port m_src2_i  in  XLEN  store data, LSB-aligned.
REQ-015 SHALL have port mem_req_o  out  1  bus request.
REQ-016 SHALL have port mem_we_o  out  1  1 write, 0 read.
REQ-017 SHALL have port mem_addr_o  out  XLEN  word-aligned address (bits [1:0] = 0).
REQ-018 SHALL have port mem_wdata_o  out  XLEN  lane-shifted store data.
REQ-019 SHALL have port mem_wstrb_o  out  4  byte strobes.
REQ-020 SHALL have port mem_ack_i  in  1  request completed; read data valid.
REQ-021 SHALL have port mem_rdata_i  in  XLEN  read word.
REQ-022 SHALL have port w_valid_o  out  1  result valid to writeback.
REQ-023 SHALL have port w_ready_i  in  1  writeback accepts.
REQ-024 SHALL have port w_pc_o  out  XLEN  PC of held entry.
REQ-025 SHALL have port w_rd_o  out  5  destination of held entry.
REQ-026 SHALL have port w_wenReg_o  out  1  register write enable of held entry.
REQ-027 SHALL have port w_res_o  out  XLEN  load data or passed-through m_res_i.
REQ-028 SHALL have port w_misal_o  out  1  held entry was a misaligned access.
REQ-029 SHALL have port byp_rd_o  out  5  rd of entry in BUS or HOLD, else 0.

Function
REQ-030 SHALL implement FSM IDLE, BUS, HOLD; m_ready_o = rst_i & (IDLE | (HOLD & w_ready_i)).
REQ-031 SHALL on accept (m_valid_i & m_ready_o) register all entry fields; aligned load/store -> BUS, else -> HOLD with w_res_o = m_res_i.
REQ-032 SHALL assert mem_req_o only in BUS; addr/we/wdata/wstrb stable until mem_ack_i; on ack -> HOLD.
REQ-033 SHALL treat m_wenMem_i & m_renMem_i both set as a store.
REQ-034 SHALL compute wstrb = mask << addr[1:0] and wdata = src2 << 8*addr[1:0].
REQ-035 SHALL form load result = rdata >> 8*addr[1:0], truncated to size, sign-extended from bit 7/15 if signed else zero-extended; word unchanged.
REQ-036 SHALL treat mask values other than 0001/0011 as word.
REQ-037 SHALL classify half with addr[0]=1 or word with addr[1:0]!=0 as misaligned: no bus request, -> HOLD, w_misal_o=1, w_wenReg_o=0, w_res_o = address.
REQ-038 SHALL give stores w_res_o = address and w_wenReg_o as received.
REQ-039 SHALL assert w_valid_o exactly in HOLD; fields stable while w_valid_o & !w_ready_i.
REQ-040 SHALL in HOLD with w_ready_i and no new accept go to IDLE; with accept take the next entry same cycle (back-to-back, no bubble for non-memory).
REQ-041 SHALL give latency: non-memory/misaligned w_valid_o 1 cycle after accept; memory w_valid_o 1 cycle after mem_ack_i; mem_req_o first high 1 cycle after accept.
REQ-042 SHALL ignore mem_ack_i outside BUS.

Reset
REQ-043 SHALL on rst_i=0 immediately enter IDLE and clear all outputs to 0 (m_ready_o=0), abandoning any BUS request.
REQ-044 SHALL after rst_i deasserts show m_ready_o=1, all other outputs 0.

Verification
REQ-045 SHALL cover: non-mem entry res=0x1234, rd=5, w_ready_i=1 -> w_valid_o next cycle, w_res_o=0x1234, byp_rd_o=5.
REQ-046 SHALL cover: signed byte load addr 0x103, rdata 0x80FFFFFF, ack 3 cycles later -> mem_addr_o=0x100, w_res_o=0xFFFFFF80.
REQ-047 SHALL cover: half store addr 0x202, src2 0xABCD -> mem_wstrb_o=1100, mem_wdata_o=0xABCD0000, mem_we_o=1.
REQ-048 SHALL cover: word load addr 0x301 -> no mem_req_o, w_misal_o=1, w_wenReg_o=0, w_res_o=0x301.
REQ-049 SHALL cover: w_ready_i low 4 cycles in HOLD -> outputs stable, m_ready_o=0; rst_i pulse in BUS -> mem_req_o drops same cycle.

Source files
------------

// File: rtl/ls_unit_if.sv
// Load/store unit connection bundle: upstream entry, memory bus and writeback port.
// Signal names keep the unit's point of view (_i into the unit, _o out of it).
interface ls_unit_if #(
    parameter int XLEN = 32
);
    logic            m_valid_i;
    logic            m_ready_o;
    logic [XLEN-1:0] m_pc_i;
    logic [4:0]      m_rd_i;
    logic            m_wenReg_i;
    logic            m_wenMem_i;
    logic            m_renMem_i;
    logic            m_is_load_signed_i;
    logic [3:0]      m_mask_i;
    logic [XLEN-1:0] m_res_i;
    logic [XLEN-1:0] m_src2_i;

    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [3:0]      mem_wstrb_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;

    logic            w_valid_o;
    logic            w_ready_i;
    logic [XLEN-1:0] w_pc_o;
    logic [4:0]      w_rd_o;
    logic            w_wenReg_o;
    logic [XLEN-1:0] w_res_o;
    logic            w_misal_o;
    logic [4:0]      byp_rd_o;

    modport master (
        output m_valid_i, m_pc_i, m_rd_i, m_wenReg_i, m_wenMem_i, m_renMem_i,
               m_is_load_signed_i, m_mask_i, m_res_i, m_src2_i,
               mem_ack_i, mem_rdata_i, w_ready_i,
        input  m_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
               w_valid_o, w_pc_o, w_rd_o, w_wenReg_o, w_res_o, w_misal_o, byp_rd_o
    );

    modport slave (
        input  m_valid_i, m_pc_i, m_rd_i, m_wenReg_i, m_wenMem_i, m_renMem_i,
               m_is_load_signed_i, m_mask_i, m_res_i, m_src2_i,
               mem_ack_i, mem_rdata_i, w_ready_i,
        output m_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
               w_valid_o, w_pc_o, w_rd_o, w_wenReg_o, w_res_o, w_misal_o, byp_rd_o
    );
endinterface

// File: rtl/ls_unit.sv
// Single-entry load/store stage: accepts one entry, runs at most one bus access,
// then holds the result for writeback. Misaligned accesses skip the bus.
module ls_unit #(
    parameter int XLEN = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ls_unit_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rd_q, rd_d;
    logic            wen_reg_q, wen_reg_d;
    logic            misal_q, misal_d;
    logic            we_q, we_d;
    logic            signed_q, signed_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;

    logic [1:0]      in_size;
    logic [1:0]      in_off;
    logic [3:0]      in_mask;
    logic            in_mem;
    logic            in_misal;
    logic            m_ready;
    logic            accept;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    // Odd mask encodings fall back to word size.
    always_comb begin
        in_size = SZ_WORD;
        in_mask = 4'b1111;
        if (bus.m_mask_i == 4'b0001) begin
            in_size = SZ_BYTE;
            in_mask = 4'b0001;
        end else if (bus.m_mask_i == 4'b0011) begin
            in_size = SZ_HALF;
            in_mask = 4'b0011;
        end
    end

    assign in_off   = bus.m_res_i[1:0];
    assign in_mem   = bus.m_wenMem_i | bus.m_renMem_i;
    assign in_misal = in_mem & (((in_size == SZ_HALF) & in_off[0]) |
                                ((in_size == SZ_WORD) & (in_off != 2'b00)));

    assign m_ready = rst_i & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.w_ready_i));
    assign accept  = bus.m_valid_i & m_ready;

    assign shifted = bus.mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            SZ_BYTE: load_data = {{(XLEN-8){signed_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{(XLEN-16){signed_q & shifted[15]}}, shifted[15:0]};
            default: load_data = bus.mem_rdata_i;
        endcase
    end

    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        wen_reg_d = wen_reg_q;
        misal_d   = misal_q;
        we_d      = we_q;
        signed_d  = signed_q;
        size_d    = size_q;
        off_d     = off_q;
        res_d     = res_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (state_q)
            ST_BUS: begin
                if (bus.mem_ack_i) begin
                    if (!we_q) res_d = load_data;
                    state_d = ST_HOLD;
                end
            end
            ST_IDLE, ST_HOLD: begin
                if (state_q == ST_HOLD && bus.w_ready_i) state_d = ST_IDLE;
                if (accept) begin
                    pc_d      = bus.m_pc_i;
                    rd_d      = bus.m_rd_i;
                    wen_reg_d = bus.m_wenReg_i & ~in_misal;
                    misal_d   = in_misal;
                    we_d      = bus.m_wenMem_i;
                    signed_d  = bus.m_is_load_signed_i;
                    size_d    = in_size;
                    off_d     = in_off;
                    // Address doubles as the result for stores and misaligned accesses.
                    res_d     = bus.m_res_i;
                    addr_d    = {bus.m_res_i[XLEN-1:2], 2'b00};
                    wdata_d   = bus.m_src2_i << {in_off, 3'b000};
                    wstrb_d   = in_mask << in_off;
                    state_d   = (in_mem && !in_misal) ? ST_BUS : ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset clears every
    // flop so all outputs read zero while rst_i is low.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            rd_q      <= '0;
            wen_reg_q <= 1'b0;
            misal_q   <= 1'b0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= SZ_BYTE;
            off_q     <= '0;
            res_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            wen_reg_q <= wen_reg_d;
            misal_q   <= misal_d;
            we_q      <= we_d;
            signed_q  <= signed_d;
            size_q    <= size_d;
            off_q     <= off_d;
            res_q     <= res_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign bus.m_ready_o   = m_ready;
    assign bus.mem_req_o   = (state_q == ST_BUS);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_wstrb_o = wstrb_q;
    assign bus.w_valid_o   = (state_q == ST_HOLD);
    assign bus.w_pc_o      = pc_q;
    assign bus.w_rd_o      = rd_q;
    assign bus.w_wenReg_o  = wen_reg_q;
    assign bus.w_res_o     = res_q;
    assign bus.w_misal_o   = misal_q;
    assign bus.byp_rd_o    = ((state_q == ST_BUS) || (state_q == ST_HOLD)) ? rd_q : 5'd0;
endmodule

// File: tb/tb_ls_unit.sv
// Scoreboard bench for ls_unit: directed entries push expected bus and writeback
// records; a memory responder and a writeback monitor pop and compare them.
module tb_ls_unit;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] res;
        logic        misal;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          dly;
    } bus_t;

    logic clk;
    logic rst_i;
    bit   force_ack;
    int   n_vec  = 0;
    int   n_fail = 0;
    wb_t  sb_q[$];
    bus_t bq[$];

    ls_unit_if #(.XLEN(XLEN)) bus();

    ls_unit #(.XLEN(XLEN)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wb(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                           input logic [31:0] res, input logic misal);
        wb_t e;
        e.pc = pc; e.rd = rd; e.wen = wen; e.res = res; e.misal = misal;
        sb_q.push_back(e);
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] rdata, input int dly);
        bus_t b;
        b.addr = addr; b.we = we; b.wdata = wdata; b.wstrb = wstrb; b.rdata = rdata; b.dly = dly;
        bq.push_back(b);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                         input logic wmem, input logic rmem, input logic sgn,
                         input logic [3:0] mask, input logic [31:0] res, input logic [31:0] src2);
        bus.m_valid_i          = 1'b1;
        bus.m_pc_i             = pc;
        bus.m_rd_i             = rd;
        bus.m_wenReg_i         = wen;
        bus.m_wenMem_i         = wmem;
        bus.m_renMem_i         = rmem;
        bus.m_is_load_signed_i = sgn;
        bus.m_mask_i           = mask;
        bus.m_res_i            = res;
        bus.m_src2_i           = src2;
    endtask

    // Present an entry and hold it until the unit takes it; returns 1 ns after the accepting edge.
    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                         input logic wmem, input logic rmem, input logic sgn,
                         input logic [3:0] mask, input logic [31:0] res, input logic [31:0] src2);
        int n;
        drive(pc, rd, wen, wmem, rmem, sgn, mask, res, src2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_ready_o && n < 50);
        if (!bus.m_ready_o) check("accept_timeout", 32'(bus.m_ready_o), 32'd1);
        @(posedge clk);
        #1 bus.m_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                           input logic wmem, input logic rmem, input logic sgn,
                           input logic [3:0] mask, input logic [31:0] res, input logic [31:0] src2,
                           input logic [31:0] rdata, input int dly,
                           input logic [31:0] e_res, input logic e_wen, input logic e_misal,
                           input logic use_bus, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
        if (use_bus) push_bus(e_addr, wmem, e_wdata, e_wstrb, rdata, dly);
        push_wb(pc, rd, e_wen, e_res, e_misal);
        issue(pc, rd, wen, wmem, rmem, sgn, mask, res, src2);
        drain();
    endtask

    // Writeback monitor: compares the head record every cycle w_valid_o is up.
    initial begin : monitor
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_i && bus.w_valid_o) begin
                if (sb_q.size() == 0) begin
                    check("spurious_wvalid", 32'(bus.w_valid_o), 32'd0);
                end else begin
                    e = sb_q[0];
                    check("w_pc", bus.w_pc_o, e.pc);
                    check("w_rd", 32'(bus.w_rd_o), 32'(e.rd));
                    check("w_wenReg", 32'(bus.w_wenReg_o), 32'(e.wen));
                    check("w_res", bus.w_res_o, e.res);
                    check("w_misal", 32'(bus.w_misal_o), 32'(e.misal));
                    check("byp_rd", 32'(bus.byp_rd_o), 32'(e.rd));
                    check("hold_mready", 32'(bus.m_ready_o), 32'(bus.w_ready_i));
                    if (bus.w_ready_i) sb_q.delete(0);
                end
            end
        end
    end

    // Memory responder: checks request fields every cycle and acks after the record's delay.
    initial begin : responder
        bus_t cur;
        bit   active;
        int   cnt;
        active = 1'b0;
        cnt = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o) begin
                if (!active) begin
                    if (bq.size() == 0) begin
                        check("unexpected_req", 32'(bus.mem_req_o), 32'd0);
                    end else begin
                        cur = bq.pop_front();
                        active = 1'b1;
                        cnt = cur.dly;
                    end
                end
                if (active) begin
                    check("mem_addr", bus.mem_addr_o, cur.addr);
                    check("mem_we", 32'(bus.mem_we_o), 32'(cur.we));
                    if (cur.we) begin
                        check("mem_wdata", bus.mem_wdata_o, cur.wdata);
                        check("mem_wstrb", 32'(bus.mem_wstrb_o), 32'(cur.wstrb));
                    end
                    if (cnt == 0) begin
                        bus.mem_ack_i   = 1'b1;
                        bus.mem_rdata_i = cur.rdata;
                        active = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end else begin
                active = 1'b0;
                if (force_ack) bus.mem_ack_i = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_i     = 1'b1;
        force_ack = 1'b0;
        bus.m_valid_i = 1'b0;
        bus.m_pc_i = '0; bus.m_rd_i = '0; bus.m_wenReg_i = 1'b0; bus.m_wenMem_i = 1'b0;
        bus.m_renMem_i = 1'b0; bus.m_is_load_signed_i = 1'b0; bus.m_mask_i = '0;
        bus.m_res_i = '0; bus.m_src2_i = '0;
        bus.w_ready_i = 1'b1;
        #1 rst_i = 1'b0;
        #2;
        check("rst_mready", 32'(bus.m_ready_o), 32'd0);
        check("rst_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_wvalid", 32'(bus.w_valid_o), 32'd0);
        check("rst_byp", 32'(bus.byp_rd_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("post_rst_mready", 32'(bus.m_ready_o), 32'd1);
        check("post_rst_req", 32'(bus.mem_req_o), 32'd0);
        check("post_rst_wvalid", 32'(bus.w_valid_o), 32'd0);
        check("post_rst_wres", bus.w_res_o, 32'd0);
        check("post_rst_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
        check("post_rst_byp", 32'(bus.byp_rd_o), 32'd0);
        @(posedge clk);
        #1;

        // Non-memory entry: result one cycle after accept.
        push_wb(32'h1000, 5'd5, 1'b1, 32'h1234, 1'b0);
        issue(32'h1000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h1234, 32'h0);
        @(negedge clk);
        check("nonmem_lat", 32'(bus.w_valid_o), 32'd1);
        check("nonmem_noreq", 32'(bus.mem_req_o), 32'd0);
        drain();

        // Signed byte load at 0x103, ack three cycles after the request appears.
        push_bus(32'h100, 1'b0, 32'h0, 4'h0, 32'h80FF_FFFF, 3);
        push_wb(32'h1004, 5'd6, 1'b1, 32'hFFFF_FF80, 1'b0);
        issue(32'h1004, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 32'h103, 32'h0);
        @(negedge clk);
        check("lb_req_lat", 32'(bus.mem_req_o), 32'd1);
        check("lb_addr", bus.mem_addr_o, 32'h100);
        repeat (3) begin
            @(negedge clk);
            check("lb_wait_wvalid", 32'(bus.w_valid_o), 32'd0);
        end
        @(negedge clk);
        check("lb_ack_lat", 32'(bus.w_valid_o), 32'd1);
        drain();

        // Half store at 0x202.
        push_bus(32'h200, 1'b1, 32'hABCD_0000, 4'b1100, 32'h0, 1);
        push_wb(32'h1008, 5'd0, 1'b0, 32'h202, 1'b0);
        issue(32'h1008, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h202, 32'h0000_ABCD);
        @(negedge clk);
        check("sh_req", 32'(bus.mem_req_o), 32'd1);
        check("sh_we", 32'(bus.mem_we_o), 32'd1);
        check("sh_wstrb", 32'(bus.mem_wstrb_o), 32'b1100);
        check("sh_wdata", bus.mem_wdata_o, 32'hABCD_0000);
        drain();

        // Misaligned word load: no bus request, result is the address.
        push_wb(32'h100C, 5'd9, 1'b0, 32'h301, 1'b1);
        issue(32'h100C, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h301, 32'h0);
        @(negedge clk);
        check("misal_noreq", 32'(bus.mem_req_o), 32'd0);
        check("misal_wvalid", 32'(bus.w_valid_o), 32'd1);
        check("misal_flag", 32'(bus.w_misal_o), 32'd1);
        drain();

        //       pc        rd   wen  wm   rm   sgn  mask     res           src2          rdata         dly  e_res         e_wen e_mis bus  e_addr      e_wdata       e_wstrb
        run_vec(32'h1010, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h402,      32'h0,        32'h8765_4321, 0, 32'h0000_8765, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0,        4'h0);
        run_vec(32'h1014, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h400,      32'h0,        32'h1234_F00D, 2, 32'hFFFF_F00D, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0,        4'h0);
        run_vec(32'h1018, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h501,      32'h0,        32'h1122_3344, 1, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0,        4'h0);
        run_vec(32'h101C, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 32'h502,      32'h0,        32'h117F_3344, 0, 32'h0000_007F, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0,        4'h0);
        run_vec(32'h1020, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0111, 32'h604,      32'h0,        32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 32'h604, 32'h0,        4'h0);
        run_vec(32'h1024, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 32'h703,      32'h5A,       32'h0,         0, 32'h703,       1'b1, 1'b0, 1'b1, 32'h700, 32'h5A00_0000, 4'b1000);
        run_vec(32'h1028, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h801,      32'h1111,     32'h0,         0, 32'h801,       1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0);
        run_vec(32'h102C, 5'd17, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, 32'h602,      32'h0,        32'h0,         0, 32'h602,       1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0);
        run_vec(32'h1030, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h900,      32'hDEAD_BEEF, 32'h0,        2, 32'h900,       1'b0, 1'b0, 1'b1, 32'h900, 32'hDEAD_BEEF, 4'b1111);
        run_vec(32'h1034, 5'd18, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 32'hB00,      32'h0,        32'h8000_0001, 0, 32'h8000_0001, 1'b1, 1'b0, 1'b1, 32'hB00, 32'h0,        4'h0);
        run_vec(32'h1038, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 32'h901,      32'hC3,       32'h0,         0, 32'h901,       1'b0, 1'b0, 1'b1, 32'h900, 32'h0000_C300, 4'b0010);
        run_vec(32'h103C, 5'd19, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'hFFFF_0003, 32'h0,       32'h0,         0, 32'hFFFF_0003, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0);

        // Writeback stall with a stray ack, then back-to-back take of the waiting entry.
        bus.w_ready_i = 1'b0;
        push_wb(32'h2000, 5'd20, 1'b1, 32'h55, 1'b0);
        issue(32'h2000, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h55, 32'h0);
        push_wb(32'h2004, 5'd21, 1'b1, 32'h66, 1'b0);
        drive(32'h2004, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h66, 32'h0);
        force_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stall_wvalid", 32'(bus.w_valid_o), 32'd1);
            check("stall_mready", 32'(bus.m_ready_o), 32'd0);
        end
        @(posedge clk);
        #1 bus.w_ready_i = 1'b1;
        force_ack = 1'b0;
        @(negedge clk);
        check("b2b_mready", 32'(bus.m_ready_o), 32'd1);
        @(posedge clk);
        #1 bus.m_valid_i = 1'b0;
        @(negedge clk);
        check("b2b_wvalid", 32'(bus.w_valid_o), 32'd1);
        drain();

        // Ack while idle is ignored.
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack_wvalid", 32'(bus.w_valid_o), 32'd0);
            check("idle_ack_req", 32'(bus.mem_req_o), 32'd0);
        end
        @(posedge clk);
        #1 force_ack = 1'b0;

        // Reset during a bus access drops the request at once.
        push_bus(32'hA00, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 10);
        push_wb(32'h3000, 5'd22, 1'b1, 32'h1234_5678, 1'b0);
        issue(32'h3000, 5'd22, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'hA00, 32'h0);
        @(negedge clk);
        check("rst_bus_req_before", 32'(bus.mem_req_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check("rst_bus_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_bus_mready", 32'(bus.m_ready_o), 32'd0);
        check("rst_bus_wvalid", 32'(bus.w_valid_o), 32'd0);
        check("rst_bus_byp", 32'(bus.byp_rd_o), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("rerst_mready", 32'(bus.m_ready_o), 32'd1);
        check("rerst_req", 32'(bus.mem_req_o), 32'd0);
        check("rerst_wvalid", 32'(bus.w_valid_o), 32'd0);
        check("rerst_wres", bus.w_res_o, 32'd0);
        check("rerst_addr", bus.mem_addr_o, 32'd0);
        check("rerst_byp", 32'(bus.byp_rd_o), 32'd0);
        @(posedge clk);
        #1;

        run_vec(32'h3004, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 32'hBEEF, 32'h0, 32'h0, 0,
                32'hBEEF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        repeat (2) @(posedge clk);
        check("bus_q_empty", 32'(bq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
